// File: rtl/gci_std_display_special_access_ctrl.sv
// Bus front end for the display special-address memory: buffers GCI requests in
// order and issues one single-cycle access at a time, returning one response each.
module gci_std_display_special_access_ctrl #(
  parameter logic [31:0] P_BASE_ADDR  = 32'h0000_0400,
  parameter int          P_FIFO_DEPTH = 4
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iBUS_REQ,
  output logic        oBUS_BUSY,
  input  logic        iBUS_RW,
  input  logic [31:0] iBUS_ADDR,
  input  logic [31:0] iBUS_DATA,
  output logic        oBUS_VALID,
  output logic        oBUS_ERR,
  output logic [31:0] oBUS_DATA,
  input  logic        iBUS_RESP_BUSY,
  output logic        oSPECIAL_REQ,
  output logic        oSPECIAL_RW,
  output logic [7:0]  oSPECIAL_ADDR,
  output logic [31:0] oSPECIAL_DATA,
  input  logic [31:0] iSPECIAL_DATA
);
  localparam int PW = (P_FIFO_DEPTH > 1) ? $clog2(P_FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic        rw;
    logic [7:0]  idx;
    logic [31:0] data;
    logic        err;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t        state, state_n;
  req_t          fifo [P_FIFO_DEPTH];
  req_t          wr_ent, head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, err_q;

  // Full is decided from the registered count alone, so a same-edge pop never
  // lets a request slip in while busy is showing.
  assign oBUS_BUSY = (count == CW'(P_FIFO_DEPTH));
  assign push      = iBUS_REQ && !oBUS_BUSY;
  assign head      = fifo[rd_ptr];

  always_comb begin
    wr_ent.rw   = iBUS_RW;
    wr_ent.idx  = iBUS_ADDR[9:2];
    wr_ent.data = iBUS_DATA;
    wr_ent.err  = (iBUS_ADDR[31:10] != P_BASE_ADDR[31:10]) || (iBUS_ADDR[1:0] != 2'b00);
  end

  always_ff @(posedge iCLOCK) begin
    if (push) fifo[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: state_n = S_RESP;
      S_RESP: begin
        if (!iBUS_RESP_BUSY) begin
          if (count != '0) begin
            pop     = 1'b1;
            state_n = S_ISSUE;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Access and response registers; the special strobe lasts only the ISSUE cycle.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      oSPECIAL_REQ  <= 1'b0;
      oSPECIAL_RW   <= 1'b0;
      oSPECIAL_ADDR <= '0;
      oSPECIAL_DATA <= '0;
      err_q         <= 1'b0;
      oBUS_VALID    <= 1'b0;
      oBUS_ERR      <= 1'b0;
      oBUS_DATA     <= '0;
    end else begin
      oSPECIAL_REQ <= 1'b0;
      if (pop) begin
        oSPECIAL_RW   <= head.rw;
        oSPECIAL_ADDR <= head.idx;
        oSPECIAL_DATA <= head.data;
        oSPECIAL_REQ  <= !head.err;
        err_q         <= head.err;
      end
      if (state == S_ISSUE) begin
        oBUS_VALID <= 1'b1;
        oBUS_ERR   <= err_q;
        oBUS_DATA  <= (!oSPECIAL_RW && !err_q) ? iSPECIAL_DATA : 32'h0;
      end else if (state == S_RESP && !iBUS_RESP_BUSY) begin
        oBUS_VALID <= 1'b0;
        oBUS_ERR   <= 1'b0;
        oBUS_DATA  <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_gci_std_display_special_access_ctrl.sv
// Directed bench: single-request vector table plus hand sequences for
// back-to-back, stall/full, mid-operation reset and same-edge push/pop.
module tb_gci_std_display_special_access_ctrl;
  logic        clk = 1'b0;
  logic        rstn;
  logic        req, busy, rw, valid, err, resp_busy;
  logic [31:0] addr, wdata, rdata;
  logic        sp_req, sp_rw;
  logic [7:0]  sp_addr;
  logic [31:0] sp_wdata, sp_rdata;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  logic [31:0] mem [256];

  gci_std_display_special_access_ctrl #(
    .P_BASE_ADDR(32'h0000_0400), .P_FIFO_DEPTH(4)
  ) dut (
    .iCLOCK(clk), .inRESET(rstn),
    .iBUS_REQ(req), .oBUS_BUSY(busy), .iBUS_RW(rw),
    .iBUS_ADDR(addr), .iBUS_DATA(wdata),
    .oBUS_VALID(valid), .oBUS_ERR(err), .oBUS_DATA(rdata),
    .iBUS_RESP_BUSY(resp_busy),
    .oSPECIAL_REQ(sp_req), .oSPECIAL_RW(sp_rw), .oSPECIAL_ADDR(sp_addr),
    .oSPECIAL_DATA(sp_wdata), .iSPECIAL_DATA(sp_rdata)
  );

  always #5 clk = ~clk;

  // Special memory model: combinational read, write on the strobe edge.
  assign sp_rdata = mem[sp_addr];
  always @(posedge clk) begin
    if (sp_req && sp_rw) mem[sp_addr] <= sp_wdata;
    if (sp_req) strobes <= strobes + 1;
  end

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [7:0]  exp_idx;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic r, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; rw = r; addr = a; wdata = d;
  endtask

  // Waits (bounded) for a response, checks it and the cycles waited, then consumes it.
  task automatic expect_resp(input logic [31:0] ed, input logic ee, input int gap, input string nm);
    int w = 0;
    while (!valid && w < 20) begin
      step();
      w++;
    end
    chk({nm, "_valid"}, valid, 1);
    chk({nm, "_data"}, rdata, ed);
    chk({nm, "_err"}, err, ee);
    if (gap >= 0) chk({nm, "_gap"}, w, gap);
    step();
  endtask

  logic [31:0] stall_addr [6];
  logic [31:0] stall_data [5];
  logic [31:0] f_addr [5];
  logic [31:0] f_data [5];

  initial begin
    int s0;
    int extra;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_1000;
    mem[1] = 32'h0000_0001;

    vt[0]  = '{1'b0, 32'h0000_0400, 32'h0,         1'b0, 32'h0000_1000, 8'd0};
    vt[1]  = '{1'b0, 32'h0000_0404, 32'h0,         1'b0, 32'h0000_0001, 8'd1};
    vt[2]  = '{1'b1, 32'h0000_040C, 32'h1111_2222, 1'b0, 32'h0,         8'd3};
    vt[3]  = '{1'b0, 32'h0000_040C, 32'h0,         1'b0, 32'h1111_2222, 8'd3};
    vt[4]  = '{1'b1, 32'h0000_07FC, 32'h1234_5678, 1'b0, 32'h0,         8'd255};
    vt[5]  = '{1'b0, 32'h0000_07FC, 32'h0,         1'b0, 32'h1234_5678, 8'd255};
    vt[6]  = '{1'b0, 32'h0000_0800, 32'h0,         1'b1, 32'h0,         8'd0};
    vt[7]  = '{1'b1, 32'h0000_0401, 32'hAAAA_5555, 1'b1, 32'h0,         8'd0};
    vt[8]  = '{1'b0, 32'h0000_0400, 32'h0,         1'b0, 32'h0000_1000, 8'd0};
    vt[9]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b1, 32'h0,         8'd0};
    vt[10] = '{1'b0, 32'h0000_0402, 32'h0,         1'b1, 32'h0,         8'd0};
    vt[11] = '{1'b1, 32'hFFFF_0400, 32'h5A5A_5A5A, 1'b1, 32'h0,         8'd0};
    vt[12] = '{1'b0, 32'h0000_0404, 32'h0,         1'b0, 32'h0000_0001, 8'd1};

    req = 1'b0; rw = 1'b0; addr = '0; wdata = '0; resp_busy = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst_ctl", {busy, valid, err, sp_req, sp_rw, sp_addr}, 0);
    chk("rst_data", {rdata, sp_wdata}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    step();

    // Single-request vectors from idle: strobe in cycle 2, response in cycle 3.
    for (int i = 0; i < 13; i++) begin
      send(vt[i].rw, vt[i].addr, vt[i].wdata);
      step();
      req = 1'b0;
      chk($sformatf("v%0d_c1_req", i), {valid, sp_req}, 0);
      step();
      chk($sformatf("v%0d_c2_strobe", i), sp_req, !vt[i].exp_err);
      if (!vt[i].exp_err) begin
        chk($sformatf("v%0d_c2_idx", i), sp_addr, vt[i].exp_idx);
        chk($sformatf("v%0d_c2_rw", i), sp_rw, vt[i].rw);
        if (vt[i].rw) chk($sformatf("v%0d_c2_wdata", i), sp_wdata, vt[i].wdata);
      end
      step();
      chk($sformatf("v%0d_c3_valid", i), valid, 1);
      chk($sformatf("v%0d_c3_err", i), err, vt[i].exp_err);
      chk($sformatf("v%0d_c3_data", i), rdata, vt[i].exp_data);
      chk($sformatf("v%0d_c3_strobe", i), sp_req, 0);
      step();
      chk($sformatf("v%0d_c4_valid", i), valid, 0);
    end

    // Back-to-back write then read of the same word.
    send(1'b1, 32'h0000_0408, 32'hDEAD_BEEF);
    step();
    send(1'b0, 32'h0000_0408, 32'h0);
    step();
    req = 1'b0;
    chk("b2b_wr_strobe", {sp_req, sp_rw, sp_addr}, {1'b1, 1'b1, 8'd2});
    chk("b2b_wr_wdata", sp_wdata, 32'hDEAD_BEEF);
    step();
    chk("b2b_wr_resp", {valid, err, rdata}, {1'b1, 1'b0, 32'h0});
    step();
    chk("b2b_rd_strobe", {valid, sp_req, sp_rw, sp_addr}, {1'b0, 1'b1, 1'b0, 8'd2});
    step();
    chk("b2b_rd_resp", {valid, err, rdata}, {1'b1, 1'b0, 32'hDEAD_BEEF});
    step();
    chk("b2b_done", valid, 0);

    // Two error requests back to back never strobe the memory.
    s0 = strobes;
    send(1'b0, 32'h0000_0800, 32'h0);
    step();
    send(1'b1, 32'h0000_0401, 32'hFFFF_FFFF);
    step();
    req = 1'b0;
    expect_resp(32'h0, 1'b1, -1, "err_a");
    expect_resp(32'h0, 1'b1, 1, "err_b");
    chk("err_no_strobe", strobes, s0);
    chk("err_mem0", mem[0], 32'h0000_1000);

    // Stalled consumer: one in service, four buffered, sixth refused.
    stall_addr = '{32'h400, 32'h404, 32'h408, 32'h7FC, 32'h40C, 32'h410};
    stall_data = '{32'h0000_1000, 32'h1, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1111_2222};
    resp_busy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send(1'b0, stall_addr[k], 32'h0);
      if (k == 4) chk("stall_busy_c4", busy, 0);
      if (k == 5) chk("stall_busy_c5", busy, 1);
      step();
    end
    req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall_hold%0d", k), {valid, err, rdata}, {1'b1, 1'b0, 32'h0000_1000});
      step();
    end
    chk("stall_busy_held", busy, 1);
    resp_busy = 1'b0;
    expect_resp(stall_data[0], 1'b0, 0, "stall_r0");
    chk("stall_busy_drop", busy, 0);
    for (int k = 1; k < 5; k++) expect_resp(stall_data[k], 1'b0, 1, $sformatf("stall_r%0d", k));
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      if (valid) extra++;
      step();
    end
    chk("stall_no_6th", extra, 0);

    // Reset while in RESP with two requests queued.
    resp_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(1'b0, stall_addr[k], 32'h0);
      step();
    end
    req = 1'b0;
    chk("rstmid_pre_valid", valid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rstmid_ctl", {busy, valid, err, sp_req, sp_rw, sp_addr}, 0);
    chk("rstmid_data", {rdata, sp_wdata}, 0);
    @(negedge clk) rstn = 1'b1;
    resp_busy = 1'b0;
    step();
    s0 = strobes;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      if (valid || sp_req) extra++;
      step();
    end
    chk("rstmid_silent", extra, 0);
    chk("rstmid_strobes", strobes, s0);
    chk("rstmid_busy", busy, 0);

    // Push on the same edge as a RESP-completion pop with three queued.
    f_addr = '{32'h400, 32'h404, 32'h40C, 32'h7FC, 32'h408};
    f_data = '{32'h0000_1000, 32'h1, 32'h1111_2222, 32'h1234_5678, 32'hDEAD_BEEF};
    resp_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(1'b0, f_addr[k], 32'h0);
      step();
    end
    req = 1'b0;
    chk("same_cnt_before", dut.count, 3);
    chk("same_r0", {valid, rdata}, {1'b1, f_data[0]});
    send(1'b0, f_addr[4], 32'h0);
    resp_busy = 1'b0;
    step();
    req = 1'b0;
    chk("same_cnt_after", dut.count, 3);
    chk("same_busy", busy, 0);
    expect_resp(f_data[1], 1'b0, 1, "same_r1");
    for (int k = 2; k < 5; k++) expect_resp(f_data[k], 1'b0, 1, $sformatf("same_r%0d", k));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
